// File: rtl/codix_halt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// codix_halt_ctrl_pkg
// Shared types and default constants for the halt controller.
//   halt_state_t       : FSM state encoding
//   DRAIN_TIMEOUT_DEF  : default maximum number of DRAIN cycles
//   CNT_W_DEF          : default width of the accepted-halt counter
// -----------------------------------------------------------------------------
package codix_halt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_RESUME = 2'd3
    } halt_state_t;

    localparam int DRAIN_TIMEOUT_DEF = 256;
    localparam int CNT_W_DEF         = 16;

endpackage

// File: rtl/codix_halt_sat_cnt.sv
// -----------------------------------------------------------------------------
// codix_halt_sat_cnt
// Saturating up-counter: counts inc pulses and sticks at all-ones.
// Ports:
//   CLK  in   clock
//   RST  in   asynchronous active-low reset (clears cnt)
//   inc  in   increment request for this cycle
//   cnt  out  [CNT_W-1:0] current count
// -----------------------------------------------------------------------------
module codix_halt_sat_cnt
    import codix_halt_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/codix_halt_ctrl.sv
// -----------------------------------------------------------------------------
// codix_halt_ctrl
// Halt sequencer: stops the core clock on a halt request, waits for the bus
// to drain, reports HALTED, and resumes on an external run request.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | core running, core_en = 1, watching halt_act
//   ST_DRAIN  | core clock gated, waiting for bus_busy to drop
//   ST_HALTED | platform halted, halted = 1, watching run_req
//   ST_RESUME | single-cycle hand-back before returning to RUN
//
// Ports:
//   CLK       in   core clock
//   RST       in   asynchronous active-low reset
//   halt_act  in   halt request (level)
//   bus_busy  in   outstanding bus transactions
//   run_req   in   resume request (level)
//   core_en   out  core clock-enable, 1 only in RUN (registered)
//   halted    out  1 only in HALTED (registered)
//   halt_cnt  out  [CNT_W-1:0] accepted halts, saturating
//   halt_err  out  sticky drain-timeout flag
//
// Build option: define CODIX_HALT_CTRL_TIMEOUT_EN to bound DRAIN to
// DRAIN_TIMEOUT cycles and enable halt_err. Without it DRAIN waits forever
// and halt_err is tied low.
// -----------------------------------------------------------------------------
module codix_halt_ctrl
    import codix_halt_ctrl_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             halt_act,
    input  logic             bus_busy,
    input  logic             run_req,
    output logic             core_en,
    output logic             halted,
    output logic [CNT_W-1:0] halt_cnt,
    output logic             halt_err
);

    if (DRAIN_TIMEOUT < 2) begin : g_bad_timeout
        $error("codix_halt_ctrl: DRAIN_TIMEOUT must be at least 2");
    end

    halt_state_t r_state;
    halt_state_t w_next;
    logic        r_core_en;
    logic        r_halted;
    logic        w_halt_inc;
    logic        w_timeout;

`ifdef CODIX_HALT_CTRL_TIMEOUT_EN
    localparam int              DW        = $clog2(DRAIN_TIMEOUT);
    localparam logic [DW-1:0]   DRAIN_END = DW'(DRAIN_TIMEOUT - 1);

    logic [DW-1:0] r_drain_cnt;
    logic          r_halt_err;

    // Counter reads k-1 in the k-th DRAIN cycle; the FSM always leaves DRAIN
    // at DRAIN_END, so the increment never wraps.
    assign w_timeout = (r_state == ST_DRAIN) && bus_busy && (r_drain_cnt == DRAIN_END);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_drain_cnt <= '0;
            r_halt_err  <= 1'b0;
        end else begin
            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end
            if (w_timeout) begin
                r_halt_err <= 1'b1;
            end
        end
    end

    assign halt_err = r_halt_err;
`else
    assign w_timeout = 1'b0;
    assign halt_err  = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_halt_inc = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (halt_act) begin
                    w_next     = ST_DRAIN;
                    w_halt_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!bus_busy || w_timeout) begin
                    w_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (run_req) begin
                    w_next = ST_RESUME;
                end
            end
            ST_RESUME: w_next = ST_RUN;
            default:   w_next = ST_RUN;
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_state
    // while still coming straight out of flops.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_RUN;
            r_core_en <= 1'b1;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_core_en <= (w_next == ST_RUN);
            r_halted  <= (w_next == ST_HALTED);
        end
    end

    assign core_en = r_core_en;
    assign halted  = r_halted;

    codix_halt_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (w_halt_inc),
        .cnt (halt_cnt)
    );

endmodule

// File: tb/tb_codix_halt_ctrl.sv
module tb_codix_halt_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       halt_act;
    logic       bus_busy;
    logic       run_req;
    logic       core_en;
    logic       halted;
    logic [1:0] halt_cnt;
    logic       halt_err;

    codix_halt_ctrl #(
        .DRAIN_TIMEOUT (8),
        .CNT_W         (2)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .halt_act (halt_act),
        .bus_busy (bus_busy),
        .run_req  (run_req),
        .core_en  (core_en),
        .halted   (halted),
        .halt_cnt (halt_cnt),
        .halt_err (halt_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       ce;
        logic       h;
        logic [1:0] cnt;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic exp_err = 1'b0;
    event chk_evt;

    // Scoreboard monitor: drains the expectation queue at each negedge, or
    // immediately when the stimulus needs a check with no clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK or chk_evt);
            while (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (core_en !== e.ce || halted !== e.h || halt_cnt !== e.cnt || halt_err !== e.err) begin
                    n_miss++;
                    $display("FAIL %s: got core_en=%b halted=%b halt_cnt=%0d halt_err=%b, expected core_en=%b halted=%b halt_cnt=%0d halt_err=%b",
                             e.name, core_en, halted, halt_cnt, halt_err, e.ce, e.h, e.cnt, e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected run to complete");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic ce, input logic h,
                              input logic [1:0] c, input logic err);
        exp_t e;
        e.name = nm;
        e.ce   = ce;
        e.h    = h;
        e.cnt  = c;
        e.err  = err;
        q.push_back(e);
    endtask

    task automatic halt_round(input string nm);
        halt_act = 1'b1;
        step();
        halt_act = 1'b0;
        expect_now({nm, "_drain"}, 1'b0, 1'b0, 2'd3, exp_err);
        step();
        expect_now({nm, "_halted"}, 1'b0, 1'b1, 2'd3, exp_err);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        step();
        expect_now({nm, "_run"}, 1'b1, 1'b0, 2'd3, exp_err);
    endtask

    initial begin
        RST      = 1'b0;
        halt_act = 1'b0;
        bus_busy = 1'b0;
        run_req  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        expect_now("reset", 1'b1, 1'b0, 2'd0, 1'b0);
        RST = 1'b1;
        step();
        expect_now("run_idle", 1'b1, 1'b0, 2'd0, 1'b0);

        // Basic halt with an idle bus
        halt_act = 1'b1;
        step();
        halt_act = 1'b0;
        expect_now("halt_core_en_low", 1'b0, 1'b0, 2'd1, 1'b0);
        step();
        expect_now("halt_halted", 1'b0, 1'b1, 2'd1, 1'b0);

        // Resume: core_en back two cycles after run_req
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        expect_now("resume_state", 1'b0, 1'b0, 2'd1, 1'b0);
        step();
        expect_now("resume_core_en", 1'b1, 1'b0, 2'd1, 1'b0);

        // Drain with bus busy for 5 DRAIN cycles
        bus_busy = 1'b1;
        halt_act = 1'b1;
        step();
        halt_act = 1'b0;
        expect_now("drain_enter", 1'b0, 1'b0, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_now("drain_wait", 1'b0, 1'b0, 2'd2, 1'b0);
        end
        bus_busy = 1'b0;
        step();
        expect_now("drain_done", 1'b0, 1'b1, 2'd2, 1'b0);

        // halt_act ignored in HALTED and RESUME
        run_req  = 1'b1;
        halt_act = 1'b1;
        step();
        run_req = 1'b0;
        expect_now("resume_ignore_halt", 1'b0, 1'b0, 2'd2, 1'b0);
        step();
        expect_now("run_after_resume", 1'b1, 1'b0, 2'd2, 1'b0);

        // Simultaneous halt_act and run_req in RUN is a halt
        run_req = 1'b1;
        step();
        halt_act = 1'b0;
        expect_now("simul_drain", 1'b0, 1'b0, 2'd3, 1'b0);
        step();
        expect_now("drain_ignore_run", 1'b0, 1'b1, 2'd3, 1'b0);
        step();
        run_req = 1'b0;
        expect_now("resume2", 1'b0, 1'b0, 2'd3, 1'b0);
        step();
        expect_now("run2", 1'b1, 1'b0, 2'd3, 1'b0);

        // Rounds 4 and 5: counter must stay saturated at 3
        halt_round("sat4");
        halt_round("sat5");

        // Bus stuck busy
        bus_busy = 1'b1;
        halt_act = 1'b1;
        step();
        halt_act = 1'b0;
        expect_now("to_enter", 1'b0, 1'b0, 2'd3, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            expect_now("to_wait", 1'b0, 1'b0, 2'd3, 1'b0);
        end
        step();
`ifdef CODIX_HALT_CTRL_TIMEOUT_EN
        expect_now("to_halted", 1'b0, 1'b1, 2'd3, 1'b1);
        exp_err  = 1'b1;
        bus_busy = 1'b0;
`else
        expect_now("no_timeout_still_drain", 1'b0, 1'b0, 2'd3, 1'b0);
        bus_busy = 1'b0;
        step();
        expect_now("no_timeout_halted", 1'b0, 1'b1, 2'd3, 1'b0);
`endif
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        step();
        expect_now("err_after_resume", 1'b1, 1'b0, 2'd3, exp_err);

        // Async reset in the middle of DRAIN
        bus_busy = 1'b1;
        halt_act = 1'b1;
        step();
        halt_act = 1'b0;
        expect_now("pre_rst_drain", 1'b0, 1'b0, 2'd3, exp_err);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        expect_now("async_rst", 1'b1, 1'b0, 2'd0, 1'b0);
        ->chk_evt;
        #1;
        bus_busy = 1'b0;
        exp_err  = 1'b0;
        step();
        RST = 1'b1;
        step();
        expect_now("post_rst_run", 1'b1, 1'b0, 2'd0, 1'b0);

        @(negedge CLK);
        #1;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL sb_drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/codix_halt_ctrl.md
CODIX_HALT_CTRL -- requirements
Module: codix_halt_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK is the single clock, and RST is the reset (asserted when RST = 0, released on the rising edge of RST).
REQ-002 Parameter DRAIN_TIMEOUT SHALL default to 256 and is the maximum number of DRAIN cycles; it SHALL be at least 2.
REQ-003 Parameter CNT_W SHALL default to 16 and is the width of halt_cnt.
REQ-004 CLK  input  1  core clock; all state changes on posedge.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 halt_act  input  1  halt functional-unit activation from the main controller; level sampled each cycle.
REQ-007 bus_busy  input  1  core has outstanding bus transactions.
REQ-008 run_req  input  1  external resume request; level sampled each cycle.
REQ-009 core_en  output  1  core clock-enable; 1 only in RUN.
REQ-010 halted  output  1  platform halted status; 1 only in HALTED.
REQ-011 halt_cnt  output  CNT_W  number of accepted halts; saturating.
REQ-012 halt_err  output  1  sticky flag set when a drain times out.

Function
REQ-013 The FSM SHALL have exactly four states: RUN, DRAIN, HALTED, and RESUME.
REQ-014 In RUN, halt_act = 1 SHALL move the FSM to DRAIN on the next posedge and increment halt_cnt by 1.
REQ-015 In RUN, halt_act = 1 and run_req = 1 together SHALL be treated as a halt; run_req is ignored.
REQ-016 In DRAIN, bus_busy = 0 SHALL move the FSM to HALTED on the next posedge.
REQ-017 In DRAIN, bus_busy = 1 SHALL keep the FSM in DRAIN, subject to REQ-028.
REQ-018 In HALTED, run_req = 1 SHALL move the FSM to RESUME; in HALTED, halt_act SHALL be ignored.
REQ-019 RESUME SHALL last exactly one cycle and then return to RUN; halt_act and run_req SHALL be ignored in RESUME.
REQ-020 halt_act and run_req SHALL be ignored in DRAIN.
REQ-021 core_en and halted SHALL be registered decodes of the state, with no combinational path from any input.
REQ-022 Latency from halt_act high to core_en low SHALL be 1 cycle.
REQ-023 Minimum latency from halt_act high to halted high SHALL be 2 cycles, when bus_busy is already 0.
REQ-024 Latency from run_req high in HALTED to core_en high SHALL be 2 cycles.
REQ-025 halt_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.

Reset
REQ-026 While RST = 0, the block SHALL hold: state RUN, core_en = 1, halted = 0, halt_cnt = 0, halt_err = 0, drain counter = 0.
REQ-027 If reset is asserted mid-DRAIN or in HALTED, the FSM SHALL return to RUN immediately, without waiting for a clock edge.

Configuration
REQ-028 With CODIX_HALT_CTRL_TIMEOUT_EN defined, the block SHALL behave as follows:
- A drain counter clears on entry to DRAIN and increments every DRAIN cycle.
- If bus_busy is still 1 in the DRAIN_TIMEOUT-th DRAIN cycle, the FSM moves to HALTED on the next posedge.
- In that case halt_err is set to 1 and stays at 1 until reset.
REQ-029 Without CODIX_HALT_CTRL_TIMEOUT_EN defined, the block SHALL behave as follows:
- No drain counter is present.
- DRAIN waits for bus_busy = 0 indefinitely.
- halt_err is tied to 0.

Structure
REQ-030 Package codix_halt_ctrl_pkg SHALL hold the state enum typedef halt_state_t and the default constants for DRAIN_TIMEOUT and CNT_W.
REQ-031 The saturating halt counter SHALL be the single sub-module codix_halt_sat_cnt, with inputs CLK, RST and inc, and output cnt.
REQ-032 The FSM and the timeout counter SHALL reside in codix_halt_ctrl.

Verification
REQ-033 Basic halt: with bus_busy = 0, pulse halt_act for one cycle at cycle 10. Required: core_en = 0 at cycle 11, halted = 1 at cycle 12, halt_cnt = 1.
REQ-034 Drain: hold bus_busy = 1 for 5 cycles after entering DRAIN. Required: halted rises exactly 1 cycle after bus_busy falls, and halt_err = 0.
REQ-035 Timeout (macro on, DRAIN_TIMEOUT = 8): hold bus_busy = 1 permanently. Required: halted = 1 after 8 DRAIN cycles, halt_err = 1, and halt_err persists through resume.
REQ-036 Resume and simultaneous events:
- In HALTED, assert run_req: core_en = 1 two cycles later.
- In RUN, assert halt_act and run_req together: FSM enters DRAIN.
REQ-037 Saturation and reset: with CNT_W = 2, perform 5 halt/resume rounds; halt_cnt = 3. Then assert RST low mid-DRAIN: core_en = 1 and halt_cnt = 0 without waiting for a clock edge.
